// File: rtl/csd_pkg.sv
// Shared CSD definitions: digit codes and encoder FSM state encoding.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package csd_pkg;

  // Digit codes stored in the CSD digit memory; the datapath zero-detect
  // compares against CSD_POS, so these must stay in lockstep with it.
  localparam logic [7:0] CSD_POS  = 8'h01;
  localparam logic [7:0] CSD_NEG  = 8'hFF;
  localparam logic [7:0] CSD_ZERO = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } csd_state_t;

endpackage

// File: rtl/csd_encoder_if.sv
// Request/response and memory-write bundle of the CSD encoder.
// Latency: none (wires only).
// Backpressure: none; start is a one-cycle request sampled only when idle.
interface csd_encoder_if #(
  parameter int WIDTH = 15,
  parameter int AW    = 4
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [7:0]       mem_data;
  logic [AW:0]      nz_count;

  modport master (
    output start, din,
    input  busy, done, mem_we, mem_addr, mem_data, nz_count
  );

  modport slave (
    input  start, din,
    output busy, done, mem_we, mem_addr, mem_data, nz_count
  );
endinterface

// File: rtl/csd_digit_cell.sv
// One CSD recoding step: (x0, x1, carry) -> digit code, carry out, non-zero flag.
// Latency: combinational.
// Backpressure: none.
module csd_digit_cell
  import csd_pkg::*;
(
  input  logic       x0,
  input  logic       x1,
  input  logic       c_in,
  output logic [7:0] code,
  output logic       c_out,
  output logic       nz
);

  // d = x0 + c_in - 2*maj(x0,x1,c_in): non-zero only when exactly one of
  // x0/c_in is set, and then its sign is chosen by x1 (x1=1 pushes the carry on).
  always_comb begin
    c_out = (x0 & x1) | (x0 & c_in) | (x1 & c_in);
    nz    = x0 ^ c_in;
    code  = CSD_ZERO;
    if (nz) begin
      code = x1 ? CSD_NEG : CSD_POS;
    end
  end

endmodule

// File: rtl/csd_encoder.sv
// Serial binary-to-CSD recoder writing WIDTH+1 digit codes LSB first to the digit memory.
// Latency: digit k written in cycle T0+1+k after start acceptance; done pulses at T0+WIDTH+2.
// Backpressure: none; start is ignored unless idle, din is latched only on acceptance.
module csd_encoder
  import csd_pkg::*;
#(
  parameter int WIDTH = 15,
  parameter int AW    = 4
) (
  input  logic           clk,
  input  logic           reset,
  csd_encoder_if.slave   bus
);

  localparam logic [AW-1:0] LAST = AW'(WIDTH);

  csd_state_t     state;
  logic [WIDTH:0] sr;
  logic           c;
  logic [AW:0]    cnt;

  logic       cell_x0;
  logic       cell_x1;
  logic       cell_c;
  logic [7:0] cell_code;
  logic       cell_c_out;
  logic       cell_nz;

  // Digit 0 is recoded straight from din on the accepting edge so the first
  // write lands in the very next cycle; later digits come from the shift register.
  always_comb begin
    cell_x0 = sr[0];
    cell_x1 = sr[1];
    cell_c  = c;
    if (state == IDLE) begin
      cell_x0 = bus.din[0];
      cell_x1 = bus.din[1];
      cell_c  = 1'b0;
    end
  end

  csd_digit_cell u_cell (
    .x0    (cell_x0),
    .x1    (cell_x1),
    .c_in  (cell_c),
    .code  (cell_code),
    .c_out (cell_c_out),
    .nz    (cell_nz)
  );

  // Conversion FSM with registered memory-write and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sr           <= '0;
      c            <= 1'b0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= CSD_ZERO;
      bus.nz_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr           <= {2'b00, bus.din[WIDTH-1:1]};
            c            <= cell_c_out;
            cnt          <= {{AW{1'b0}}, cell_nz};
            bus.busy     <= 1'b1;
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= '0;
            bus.mem_data <= cell_code;
            state        <= RUN;
          end
        end
        RUN: begin
          // The digit currently on the bus is the last one: close out the run.
          if (bus.mem_addr == LAST) begin
            bus.busy     <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_data <= CSD_ZERO;
            bus.done     <= 1'b1;
            bus.nz_count <= cnt;
            state        <= DONE;
          end else begin
            sr           <= sr >> 1;
            c            <= cell_c_out;
            cnt          <= cnt + {{AW{1'b0}}, cell_nz};
            bus.mem_addr <= bus.mem_addr + 1'b1;
            bus.mem_data <= cell_code;
          end
        end
        DONE: begin
          bus.done     <= 1'b0;
          bus.mem_addr <= '0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csd_encoder.sv
// Self-checking bench for csd_encoder: directed and random words against an arithmetic CSD model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_csd_encoder;

  localparam int WIDTH = 15;
  localparam int AW    = 4;
  localparam int ND    = WIDTH + 1;

  logic clk;
  logic reset;

  csd_encoder_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  csd_encoder #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  logic [7:0] exp_mem [ND];
  int         exp_nz;
  logic [7:0] cap     [ND];
  int         wr_cnt;
  int         addr_bad;
  int         busy_bad;
  int         done_cnt;
  int         done_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference recoding: repeatedly pick the digit in {-1,0,+1} that makes
  // the remaining value divisible by 4 (non-adjacent form), then halve.
  task automatic build_ref(input logic [WIDTH-1:0] v);
    int n;
    n = int'(v);
    exp_nz = 0;
    for (int k = 0; k < ND; k++) begin
      if (n % 2 == 1) begin
        if (n % 4 == 1) begin
          exp_mem[k] = 8'h01;
          n = (n - 1) / 2;
        end else begin
          exp_mem[k] = 8'hFF;
          n = (n + 1) / 2;
        end
        exp_nz++;
      end else begin
        exp_mem[k] = 8'h00;
        n = n / 2;
      end
    end
  endtask

  task automatic sample(input int n);
    if (bus.mem_we === 1'b1) begin
      if (int'(bus.mem_addr) != wr_cnt) addr_bad++;
      cap[bus.mem_addr] = bus.mem_data;
      wr_cnt++;
    end
    if (bus.busy !== bus.mem_we) busy_bad++;
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = n;
    end
  endtask

  // One conversion; optionally fires a second start (din=7FFF) mid-run.
  task automatic run_conv(input string tag, input logic [WIDTH-1:0] v,
                          input bit inject2, input int exp_nz_const);
    build_ref(v);
    for (int i = 0; i < ND; i++) cap[i] = 8'hAA;
    wr_cnt = 0; addr_bad = 0; busy_bad = 0; done_cnt = 0; done_cyc = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.din   = v;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      sample(n);
      if (inject2 && n == 3) begin
        bus.start = 1'b1;
        bus.din   = 15'h7FFF;
      end
      if (n == 4) bus.start = 1'b0;
      @(negedge clk);
    end
    check({tag, " writes"}, wr_cnt, ND);
    check({tag, " addr_seq"}, addr_bad, 0);
    check({tag, " busy_eq_we"}, busy_bad, 0);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " done_cycle"}, done_cyc, WIDTH + 2);
    check({tag, " nz_count"}, bus.nz_count, exp_nz);
    if (exp_nz_const >= 0) check({tag, " nz_const"}, bus.nz_count, exp_nz_const);
    for (int i = 0; i < ND; i++) begin
      check($sformatf("%s digit%0d", tag, i), cap[i], exp_mem[i]);
    end
  endtask

  initial begin
    int dn;
    logic [WIDTH-1:0] rv;
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.din = '0;
    repeat (3) @(negedge clk);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst mem_we", bus.mem_we, 0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst mem_data", bus.mem_data, 8'h00);
    check("rst nz_count", bus.nz_count, 0);
    reset = 1'b1;
    @(negedge clk);

    run_conv("d0007", 15'h0007, 1'b0, 2);
    check("d0007 addr0", cap[0], 8'hFF);
    check("d0007 addr3", cap[3], 8'h01);
    run_conv("d0000", 15'h0000, 1'b0, 0);
    run_conv("d7FFF", 15'h7FFF, 1'b0, 2);
    check("d7FFF addr15", cap[15], 8'h01);
    run_conv("d5555", 15'h5555, 1'b0, 8);
    run_conv("ignored_start", 15'h0003, 1'b1, 2);
    check("ignored_start addr2", cap[2], 8'h01);

    // Reset five cycles into a conversion.
    @(negedge clk);
    bus.start = 1'b1;
    bus.din   = 15'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort mem_we", bus.mem_we, 1);
    reset = 1'b0;
    #1;
    check("abort mem_we", bus.mem_we, 0);
    check("abort busy", bus.busy, 0);
    dn = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 2) reset = 1'b1;
      if (bus.done === 1'b1 || bus.mem_we === 1'b1) dn++;
    end
    check("abort no_done_no_we", dn, 0);
    run_conv("after_abort", 15'h0007, 1'b0, 2);

    for (int r = 0; r < 6; r++) begin
      rv = WIDTH'($urandom);
      run_conv($sformatf("rnd%0d_%h", r, rv), rv, 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csd_encoder.md
# csd_encoder

Serial binary-to-CSD recoder that fills the CSD digit memory ahead of the CSD datapath. On `start` it latches an unsigned word and produces one canonical-signed-digit per cycle, LSB first. Each digit is written as an 8-bit code to consecutive addresses 0..WIDTH through the memory write port (`we`/`dataIn`/`address`). It also reports the non-zero digit count, so the downstream control can run its scan loop as soon as `done` pulses.

## Interface
- `WIDTH`, default 15: input word width. Digit count is WIDTH+1; this must equal the memory depth (16).
- `AW`, default 4: memory address width. Requires 2^AW ≥ WIDTH+1.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `din`  in  WIDTH  unsigned operand. Latched on an accepted `start`.
- `busy`  out  1  high from the cycle after `start` acceptance through the last digit write.
- `done`  out  1  one-cycle pulse after the last digit write.
- `mem_we`  out  1  digit write strobe. Drives memory `we`.
- `mem_addr`  out  AW  digit index. Drives memory `address`.
- `mem_data`  out  8  digit code. Drives memory `dataIn`.
- `nz_count`  out  AW+1  number of non-zero digits in the last completed conversion.

## Operation
- Digit codes: +1 = 8'h01, −1 = 8'hFF, 0 = 8'h00.
- FSM states:
  - IDLE: on `start`, load shift register `sr`={1'b0,`din`}, carry `c`=0, index `k`=0, running count=0, then go to RUN. Otherwise stay in IDLE.
  - RUN: one digit per cycle, then go to DONE after the write with `k`=WIDTH.
  - DONE: assert `done` for one cycle, update `nz_count`, then return to IDLE.
- Recoding rule (LSB first), with x0=`sr[0]` and x1=`sr[1]`:
  - c_next = maj(x0, x1, c).
  - d = x0 + c − 2·c_next, which is always in {−1, 0, +1}.
  - Then shift `sr` right with zero fill, set c←c_next, increment `k`, and increment the running count when d≠0.
- The final digit (k=WIDTH) sees x0=0 and x1=0, so it equals the carry and the final carry out is 0. The result never needs more than WIDTH+1 digits.
- `start` while not in IDLE is ignored, and `din` is not re-latched.
- `nz_count` holds its value until the next DONE. Maximum value is ceil((WIDTH+1)/2) = 8.

## Timing
- Reset (async assert, sync release): state=IDLE; `busy`, `done`, `mem_we` = 0; `mem_addr` = 0; `mem_data` = 8'h00; `nz_count` = 0.
- All outputs are registered.
- For `start` accepted at edge T0:
  - Digit k is presented on `mem_we`/`mem_addr`/`mem_data` during cycle T0+1+k, for k=0..WIDTH.
  - `done` is high during cycle T0+WIDTH+2, i.e. cycle 17 for the default.
  - The earliest next `start` is accepted in the cycle after `done`.
- `busy` covers exactly the WIDTH+1 write cycles. `mem_we` = `busy`.
- Reset asserted mid-conversion aborts it immediately: no further writes, and memory holds a partial digit string. No `done` is issued.
- `mem_addr` never exceeds WIDTH and never wraps.

## Structure
- Shared package/header `csd_pkg` holds:
  - the digit-code constants CSD_POS, CSD_NEG and CSD_ZERO;
  - the FSM state encoding (IDLE, RUN, DONE).
- These constants are shared with the CSD datapath/controller, whose zero-detect compares against CSD_POS.
- Sub-module `csd_digit_cell` is combinational. It takes (x0, x1, c_in) and returns (code[7:0], c_out, nz).
- The top level holds the FSM, shift register, carry flop, index counter, count accumulator and output registers.

## Test plan
- `din`=15'h0007 → addr0=8'hFF, addr3=8'h01, all other addresses 8'h00; `nz_count`=2; `done` in cycle 17 after `start`.
- `din`=15'h0000 → 16 writes of 8'h00 at addresses 0..15; `nz_count`=0.
- `din`=15'h7FFF → addr0=8'hFF, addr15=8'h01, rest 8'h00; `nz_count`=2.
- `din`=15'h5555 → 8'h01 at even addresses 0..14, 8'h00 at odd addresses; `nz_count`=8.
- `start` with `din`=15'h0003, then `start` with `din`=15'h7FFF during RUN → the second request is ignored; result is addr0=8'hFF, addr2=8'h01 and `nz_count`=2, with exactly 16 writes.
- Reset asserted 5 cycles into a conversion → `mem_we`/`busy` drop to 0 immediately, with no `done`. After release, a fresh `start` with `din`=15'h0007 completes normally with the first test's result.
